// File: rtl/param_readback_tx_pkg.sv
// Shared definitions for the parameter read-back UART transmitter.
// Holds the frame constants, the frame FSM encoding, the snapshot layout and the payload byte selector.
// Optional feature macro: PARAM_TX_CHECKSUM_EN (adds the CHK state to the encoding).
package param_readback_tx_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    localparam int         PAYLOAD_LEN  = 20;
    localparam logic [7:0] LEN_BYTE     = 8'(PAYLOAD_LEN);

`ifdef PARAM_TX_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        CHK  = 3'd4,
        FIN  = 3'd5
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        FIN  = 3'd5
    } tx_state_t;
`endif

    // Field order here is the wire order: the first declared field is the
    // most significant, so payload byte 0 is the top byte of the vector.
    typedef struct packed {
        logic [7:0]  per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [31:0] nut_d;
        logic [31:0] nut_w;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic [5:0]  rsvd;
        logic        bl;
        logic        pu;
    } snap_t;

    // Byte idx (0..PAYLOAD_LEN-1) of the snapshot, MSB byte first.
    function automatic logic [7:0] payload_byte(snap_t s, logic [4:0] idx);
        logic [8*PAYLOAD_LEN-1:0] v;
        int                       sh;
        v  = s;
        sh = 8 * (PAYLOAD_LEN - 1 - int'(idx));
        return v[sh +: 8];
    endfunction

endpackage

// File: rtl/param_readback_tx_if.sv
// Parameter bus from pulse_control into the read-back transmitter.
// Ports: trig (snapshot request) plus every pulse parameter word.
// master drives the bus (pulse_control / testbench), slave samples it (transmitter).
interface param_readback_tx_if;

    logic        trig;
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [31:0] nut_d;
    logic [31:0] nut_w;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        pu;
    logic        bl;

    modport master (
        output trig, per, p1wid, del, p2wid, nut_d, nut_w, cp, p_bl, p_bl_off, pu, bl
    );

    modport slave (
        input trig, per, p1wid, del, p2wid, nut_d, nut_w, cp, p_bl, p_bl_off, pu, bl
    );

endinterface

// File: rtl/param_readback_tx_uart_tx_byte.sv
// Purpose: 8N1 byte serialiser (baud counter + shift register) for host-link blocks.
// Latency: start bit drives tx the cycle after start&ready; one byte = 10*CLKS_PER_BIT cycles.
// Backpressure: ready is high when idle and in the last cycle of the stop bit, so a start then chains bytes with no gap.
// Ports: clk, resetn (async active-low), start, data[7:0] in; tx (idle high), ready out.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          byte_end;

    assign bit_end  = active_q && (cnt_q == CNT_LAST);
    // bit_q: 0 = start, 1..8 = data, 9 = stop
    assign byte_end = bit_end && (bit_q == 4'd9);
    assign ready    = !active_q || byte_end;
    assign tx       = tx_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (start && ready) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = 4'd0;
            // stop bit rides in the top of the shifter so it falls out after bit 8
            shift_d  = {1'b1, data};
            tx_d     = 1'b0;
        end else if (byte_end) begin
            active_d = 1'b0;
            cnt_d    = '0;
            bit_d    = 4'd0;
            tx_d     = 1'b1;
        end else if (bit_end) begin
            cnt_d    = '0;
            bit_d    = bit_q + 4'd1;
            tx_d     = shift_q[0];
            shift_d  = {1'b1, shift_q[8:1]};
        end else if (active_q) begin
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '1;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/param_readback_tx.sv
// Purpose: snapshots the pulse parameters on trig and streams HDR, LEN, 20 payload bytes (+CHK) as 8N1 on RS232_Tx.
// Latency: start bit on RS232_Tx the cycle after trig is sampled; frame = 22 (23 with CHK) * 10 * CLKS_PER_BIT cycles.
// Backpressure: trig while a frame is running sets one coalescing pending bit; the next frame starts the cycle after done.
// Ports: clk, resetn (async active-low), prm (parameter bus incl. trig, slave), RS232_Tx (idle high), busy, done.
// Optional feature macro PARAM_TX_CHECKSUM_EN: appends CHK = XOR of LEN and the 20 payload bytes.
module param_readback_tx
    import param_readback_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 1250,
    parameter logic [7:0] HEADER_BYTE  = FRAME_HEADER
) (
    input  logic                 clk,
    input  logic                 resetn,
    param_readback_tx_if.slave   prm,
    output logic                 RS232_Tx,
    output logic                 busy,
    output logic                 done
);

    tx_state_t  state_q, state_d;
    snap_t      snap_q, snap_d;
    snap_t      live_snap;
    logic [4:0] idx_q, idx_d;
    logic       pending_q, pending_d;
`ifdef PARAM_TX_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
`endif

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;

    assign live_snap = '{
        per:      prm.per,
        p1wid:    prm.p1wid,
        del:      prm.del,
        p2wid:    prm.p2wid,
        nut_d:    prm.nut_d,
        nut_w:    prm.nut_w,
        cp:       prm.cp,
        p_bl:     prm.p_bl,
        p_bl_off: prm.p_bl_off,
        rsvd:     6'b0,
        bl:       prm.bl,
        pu:       prm.pu
    };

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk    (clk),
        .resetn (resetn),
        .start  (tx_start),
        .data   (tx_data),
        .tx     (RS232_Tx),
        .ready  (tx_ready)
    );

    // Each state names the byte currently on the wire; the next byte is
    // handed to the serialiser in the last stop-bit cycle so bytes abut.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        pending_d = pending_q;
`ifdef PARAM_TX_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        tx_start  = 1'b0;
        tx_data   = HEADER_BYTE;

        if (prm.trig && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (prm.trig) begin
                    snap_d   = live_snap;
                    tx_start = 1'b1;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tx_data  = LEN_BYTE;
`ifdef PARAM_TX_CHECKSUM_EN
                    chk_d    = LEN_BYTE;
`endif
                    state_d  = LEN;
                end
            end
            LEN: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tx_data  = payload_byte(snap_q, 5'd0);
`ifdef PARAM_TX_CHECKSUM_EN
                    chk_d    = chk_q ^ tx_data;
`endif
                    idx_d    = 5'd0;
                    state_d  = PAY;
                end
            end
            PAY: begin
                if (tx_ready) begin
                    if (idx_q != 5'(PAYLOAD_LEN - 1)) begin
                        tx_start = 1'b1;
                        tx_data  = payload_byte(snap_q, idx_q + 5'd1);
`ifdef PARAM_TX_CHECKSUM_EN
                        chk_d    = chk_q ^ tx_data;
`endif
                        idx_d    = idx_q + 5'd1;
                    end else begin
`ifdef PARAM_TX_CHECKSUM_EN
                        tx_start = 1'b1;
                        tx_data  = chk_q;
                        state_d  = CHK;
`else
                        state_d  = FIN;
`endif
                    end
                end
            end
`ifdef PARAM_TX_CHECKSUM_EN
            CHK: begin
                if (tx_ready) begin
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                // A trig landing in this cycle is treated exactly like a pending one.
                if (pending_q || prm.trig) begin
                    snap_d    = live_snap;
                    pending_d = 1'b0;
                    tx_start  = 1'b1;
                    state_d   = HDR;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= 5'd0;
            pending_q <= 1'b0;
`ifdef PARAM_TX_CHECKSUM_EN
            chk_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
`ifdef PARAM_TX_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    // FIN is the gap cycle after the last stop bit, so busy covers exactly the serial bytes.
    assign busy = (state_q != IDLE) && (state_q != FIN);
    assign done = (state_q == FIN);

endmodule
